sio_uart_tx: RTL and testbench
==============================

Name: sio_uart_tx

Overview:
- Serial transmitter: the output counterpart of the board's UART_RX line, feeding the LM80C SIO channel A transmit path.
- Accepts bytes from the SIO register interface into a small FIFO.
- Serialises each byte as 8N1 (8 data bits, no parity, 1 stop bit), LSB first, on a single TX line.
- Runs in the sys_clock domain (3.6864 MHz x 8 = 29.4912 MHz); baud timing comes from an internal divider.

Parameters:
- CLK_DIV, 3072: sys_clock cycles per bit (29.4912 MHz / 9600 baud); legal range 2..65535.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8 entries.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock (sys_clock).
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write strobe; one byte pushed per cycle while high and not full.
- din  input  8  byte to transmit, sampled on clk when wr=1.
- full  output  1  FIFO holds 2**FIFO_AW entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  FIFO_AW+1  current FIFO occupancy.
- busy  output  1  shifter is not in IDLE.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (asynchronous assert, released on clk): tx=1, busy=0, empty=1, full=0, count=0, FIFO pointers=0, state=IDLE, baud counter=0, bit index=0.
- FIFO is synchronous, first-word fall-through to the shifter.
  - Write is ignored when full=1; no overflow corruption, count unchanged.
  - Push and pop in the same cycle leave count unchanged. This is legal even when full (pop frees the slot) and when empty with a simultaneous write is not possible (pop requires non-empty).
  - Pointers wrap modulo 2**FIFO_AW.
  - full, empty and count are registered and update on the clk edge after the write or pop.
- State machine IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. When empty=0, pop one byte into the shift register, load the baud counter with CLK_DIV-1, go to START. tx drives 0 from the next cycle.
  - Latency: wr at edge N with the FIFO empty and the shifter idle -> tx falls at edge N+2.
  - Each state holds tx for exactly CLK_DIV clk cycles. The baud counter counts down to 0, then reloads CLK_DIV-1 and advances.
  - START: tx=0 for one bit time, then DATA with bit index 0.
  - DATA: tx = shift[0]; at each bit end shift right and increment the index. After index 7, go to STOP.
  - STOP: tx=1 for STOP_BITS bit times.
  - End of STOP: if the FIFO is non-empty, pop and go directly to START with no idle gap (back-to-back frames). Otherwise go to IDLE.
- busy = (state != IDLE). It falls in the same cycle the state returns to IDLE.
- Frame length: (10 + STOP_BITS - 1) x CLK_DIV cycles; 8N1 at CLK_DIV=3072 gives 30720 cycles.
- Bytes written while a frame is in flight queue in the FIFO. The byte in the shifter is not counted in count.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the FIFO is flushed, and the partial frame is abandoned.
- No glitches: tx is driven from a register only.

Optional Feature:
- Macro SIO_UART_TX_PARITY_EN.
- When defined:
  - adds input port parity_odd (1 bit);
  - inserts a PARITY state between DATA and STOP, one bit time long;
  - tx = XOR of the 8 data bits, inverted when parity_odd=1;
  - parity_odd is sampled at the pop into the shifter;
  - frame length grows by CLK_DIV.
- When undefined: no parity_odd port, no PARITY state, frames are strictly 8N1/8N2.

Test Plan:
- Reset then idle, CLK_DIV=4: assert reset mid-frame -> tx=1 that same cycle; count=0, empty=1, busy=0; tx stays 1 for 100 cycles with no writes.
- Single byte, CLK_DIV=4: write 8'hA5 -> tx falls 2 cycles after the wr edge. Sampling at bit centres gives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). busy high for 40 cycles.
- Back-to-back, CLK_DIV=4: write 8'h55 then 8'h0F on consecutive cycles -> second start bit begins exactly 40 cycles after the first. No idle cycle between frames; count goes 1 -> 0 at the second pop.
- FIFO full, FIFO_AW=3: while the shifter is busy, write 10 bytes 8'h00..8'h09.
  - First byte goes to the shifter, next 8 fill the FIFO: full=1, count=8.
  - 10th byte dropped; transmitted sequence is 00..08.
- Simultaneous push/pop: with full=1, assert wr on the cycle the shifter pops -> count stays 8 and the new byte is transmitted last.
- SIO_UART_TX_PARITY_EN: send 8'h03 with parity_odd=0 -> parity bit 0; with parity_odd=1 -> 1. Frame is 11 bit times.

Source files
------------

// File: rtl/sio_uart_tx.sv
// SIO channel A serial transmitter: 8-entry FWFT FIFO feeding an 8N1/8N2 shifter.
// Optional parity bit between data and stop is enabled by defining SIO_UART_TX_PARITY_EN.
module sio_uart_tx #(
    parameter int CLK_DIV   = 3072,
    parameter int FIFO_AW   = 3,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [7:0]         din,
`ifdef SIO_UART_TX_PARITY_EN
    input  logic               parity_odd,
`endif
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               busy,
    output logic               tx
);

    localparam int                 DEPTH       = 2 ** FIFO_AW;
    localparam logic [15:0]        BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL    = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ZERO    = {(FIFO_AW + 1){1'b0}};
    localparam logic [FIFO_AW:0]   CNT_ONE     = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ZERO    = {FIFO_AW{1'b0}};
    localparam logic [FIFO_AW-1:0] PTR_ONE     = {{(FIFO_AW - 1){1'b0}}, 1'b1};
    localparam logic [2:0]         STOP_LAST   = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SIO_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   count_r, count_next_s;
    logic               full_r, empty_r;
    logic               push_s, pop_s;

    state_t             state_r, next_state_s;
    logic [15:0]        baud_r;
    logic [2:0]         bit_idx_r;
    logic [7:0]         shift_r;
    logic               baud_tick_s;
    logic               tx_r, tx_next_s, busy_r;
`ifdef SIO_UART_TX_PARITY_EN
    logic               parity_r;
`endif

    // A pop frees a slot in the same cycle, so a write while full is accepted only then.
    assign push_s      = wr & (~full_r | pop_s);
    assign baud_tick_s = (baud_r == 16'd0);

    // FIFO storage (no reset needed; validity tracked by pointers)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Next occupancy
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == CNT_ZERO);
        end
    end

    // Shifter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and pop decision
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick_s) next_state_s = ST_DATA;
                else             next_state_s = ST_START;
            end
            ST_DATA: begin
                if (baud_tick_s && bit_idx_r == 3'd7) begin
`ifdef SIO_UART_TX_PARITY_EN
                    next_state_s = ST_PARITY;
`else
                    next_state_s = ST_STOP;
`endif
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef SIO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick_s) next_state_s = ST_STOP;
                else             next_state_s = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (baud_tick_s && bit_idx_r == STOP_LAST) begin
                    if (!empty_r) begin
                        pop_s        = 1'b1;
                        next_state_s = ST_START;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Baud counter, bit index and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
`ifdef SIO_UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else if (pop_s) begin
            baud_r    <= BAUD_RELOAD;
            bit_idx_r <= 3'd0;
            shift_r   <= mem_r[rd_ptr_r];
`ifdef SIO_UART_TX_PARITY_EN
            parity_r  <= (^mem_r[rd_ptr_r]) ^ parity_odd;
`endif
        end else if (state_r != ST_IDLE) begin
            if (baud_tick_s) begin
                baud_r <= BAUD_RELOAD;
                if (state_r == ST_DATA) begin
                    shift_r   <= {1'b0, shift_r[7:1]};
                    bit_idx_r <= bit_idx_r + 3'd1;
                end else if (state_r == ST_STOP) begin
                    bit_idx_r <= (bit_idx_r == STOP_LAST) ? 3'd0 : bit_idx_r + 3'd1;
                end
            end else begin
                baud_r <= baud_r - 16'd1;
            end
        end
    end

    // Line level for the current state; registered one cycle behind the state
    always_comb begin
        tx_next_s = 1'b1;
        case (state_r)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_r[0];
`ifdef SIO_UART_TX_PARITY_EN
            ST_PARITY: tx_next_s = parity_r;
`endif
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Registered line and busy outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            tx_r   <= tx_next_s;
            busy_r <= (next_state_s != ST_IDLE);
        end
    end

    assign tx    = tx_r;
    assign busy  = busy_r;
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: tb/tb_sio_uart_tx.sv
// Directed bench for sio_uart_tx at CLK_DIV=4: frame timing, FIFO limits, push/pop, reset.
// Parity checks are compiled in when SIO_UART_TX_PARITY_EN is defined.
module tb_sio_uart_tx;

    localparam int CLK_DIV   = 4;
    localparam int FIFO_AW   = 3;
    localparam int STOP_BITS = 1;
`ifdef SIO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr;
    logic [7:0]       din;
    logic             full, empty, busy, tx;
    logic [FIFO_AW:0] count;
`ifdef SIO_UART_TX_PARITY_EN
    logic             parity_odd;
    logic             rx_par_q[$];
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic       rx_en;
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         rx_ferr = 0;

    sio_uart_tx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_AW   (FIFO_AW),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .din        (din),
`ifdef SIO_UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .full       (full),
        .empty      (empty),
        .count      (count),
        .busy       (busy),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit-centre sampling receiver
    task automatic rx_frame();
        logic [7:0] b;
        int         t0;
        t0 = cyc;
        b  = 8'h00;
        repeat (CLK_DIV / 2) @(posedge clk);
        #2;
        if (tx !== 1'b0) rx_ferr++;
        for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(posedge clk);
            #2;
            b[i] = tx;
        end
`ifdef SIO_UART_TX_PARITY_EN
        repeat (CLK_DIV) @(posedge clk);
        #2;
        rx_par_q.push_back(tx);
`endif
        repeat (CLK_DIV) @(posedge clk);
        #2;
        if (tx !== 1'b1) rx_ferr++;
        rx_q.push_back(b);
        rx_start_q.push_back(t0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rx_en && tx === 1'b0) rx_frame();
        end
    end

    task automatic wait_rx(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            step();
            t++;
        end
        check_val(tag, rx_q.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] frame;
        logic [7:0]  exp_b;
        int          busy_cnt;
        int          bad;

        reset = 1'b1;
        wr    = 1'b0;
        din   = 8'h00;
        rx_en = 1'b0;
`ifdef SIO_UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        step(2);
        check_val("rst_tx", tx, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_empty", empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_count", count, 0);
        reset = 1'b0;
        step(2);
        rx_en = 1'b1;

        // Single byte 0xA5: latency, bit values at centres, busy length
`ifdef SIO_UART_TX_PARITY_EN
        frame = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        frame = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        wr  = 1'b1;
        din = 8'hA5;
        step();
        wr = 1'b0;
        check_val("a5_tx_n0", tx, 1);
        busy_cnt = 0;
        for (int c = 1; c <= FRAME + 10; c++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
            if (c == 1) check_val("a5_tx_n1", tx, 1);
            if (c == 2) check_val("a5_tx_fall_n2", tx, 0);
            if (c >= 4 && (c - 4) % CLK_DIV == 0 && (c - 4) / CLK_DIV < NBITS)
                check_val($sformatf("a5_bit%0d", (c - 4) / CLK_DIV), tx, frame[(c - 4) / CLK_DIV]);
        end
        check_val("a5_busy_cycles", busy_cnt, FRAME);
        wait_rx("a5_rx_timeout", 1, 10);
        if (rx_q.size() >= 1) check_val("a5_rx_byte", rx_q[0], 8'hA5);
        rx_q.delete();
        rx_start_q.delete();

        // Back-to-back 0x55, 0x0F
        wr  = 1'b1;
        din = 8'h55;
        step();
        din = 8'h0F;
        step();
        wr = 1'b0;
        check_val("b2b_cnt_after_w2", count, 1);
        step(FRAME - 1);
        check_val("b2b_cnt_before_pop2", count, 1);
        step();
        check_val("b2b_cnt_after_pop2", count, 0);
        wait_rx("b2b_rx_timeout", 2, 3 * FRAME);
        if (rx_q.size() >= 2) begin
            check_val("b2b_byte0", rx_q[0], 8'h55);
            check_val("b2b_byte1", rx_q[1], 8'h0F);
            check_val("b2b_start_gap", rx_start_q[1] - rx_start_q[0], FRAME);
        end
        step(2 * CLK_DIV);
        check_val("b2b_idle_busy", busy, 0);
        rx_q.delete();
        rx_start_q.delete();

        // Fill the FIFO with 00..09; 09 is dropped
        for (int i = 0; i < 10; i++) begin
            wr  = 1'b1;
            din = 8'(i);
            step();
        end
        wr = 1'b0;
        check_val("fill_full", full, 1);
        check_val("fill_count", count, 8);
        step(FRAME - 9);
        check_val("fill_count_prepop", count, 8);
        // Push on the exact cycle the shifter pops the next byte
        wr  = 1'b1;
        din = 8'hAA;
        step();
        wr = 1'b0;
        check_val("pushpop_count", count, 8);
        check_val("pushpop_full", full, 1);
        wait_rx("fill_rx_timeout", 10, 12 * FRAME);
        if (rx_q.size() >= 10) begin
            for (int i = 0; i < 10; i++) begin
                exp_b = (i < 9) ? 8'(i) : 8'hAA;
                check_val($sformatf("fill_byte%0d", i), rx_q[i], exp_b);
            end
        end
        step(2 * CLK_DIV);
        check_val("fill_drained_empty", empty, 1);
        check_val("fill_drained_busy", busy, 0);
        rx_q.delete();
        rx_start_q.delete();

`ifdef SIO_UART_TX_PARITY_EN
        parity_odd = 1'b0;
        wr  = 1'b1;
        din = 8'h03;
        step();
        wr = 1'b0;
        step(2);
        parity_odd = 1'b1;
        wait_rx("par_even_timeout", 1, 2 * FRAME);
        step(2 * CLK_DIV);
        wr  = 1'b1;
        din = 8'h03;
        step();
        wr = 1'b0;
        wait_rx("par_odd_timeout", 2, 2 * FRAME);
        if (rx_par_q.size() >= 2) begin
            check_val("par_even_bit", rx_par_q[0], 0);
            check_val("par_odd_bit", rx_par_q[1], 1);
        end
        step(2 * CLK_DIV);
        rx_q.delete();
`endif

        // Reset mid-frame while data bit 0 of 0x00 is on the line
        rx_en = 1'b0;
        wr  = 1'b1;
        din = 8'h00;
        step();
        din = 8'h11;
        step();
        wr = 1'b0;
        step(8);
        check_val("mid_tx_low", tx, 0);
        reset = 1'b1;
        #1;
        check_val("mid_rst_tx", tx, 1);
        check_val("mid_rst_count", count, 0);
        check_val("mid_rst_empty", empty, 1);
        check_val("mid_rst_busy", busy, 0);
        step();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_val("post_rst_idle", bad, 0);
        check_val("post_rst_count", count, 0);
        check_val("rx_framing", rx_ferr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
